instr_encoder: RTL and testbench

Sequential RV32I instruction encoder and instruction-memory writer. Accepts one field-level instruction command per handshake, packs it into a 32-bit RV32I word using the same opcode map and immediate formats that the main decoder consumes, and writes it to consecutive instruction-memory words. Sits on the program-load path, ahead of the fetch/decode pipeline, and is used for boot loading and self-checking test program generation.

---
 rtl/instr_encoder_pkg.sv | 48 ++++
 rtl/instr_encoder_imm_packer.sv | 65 ++++++
 rtl/instr_encoder.sv | 182 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// instr_encoder shared types: command classes, opcodes, FSM states.
// Optional macro INSTR_ENC_CHECK_EN enables command range checking.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_IALU   = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8,
    CLS_SYSTEM = 4'd9
  } cmd_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // True when v is representable as an n-bit two's complement value.
  function automatic logic fits_signed(
    input logic [31:0] v,
    input int unsigned n
  );
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (n - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Places a command immediate into its RV32I bit positions.
// INSTR_ENC_CHECK_EN adds a class/range fault flag; otherwise it is 0.
module instr_encoder_imm_packer
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  i_class,
  input  logic [2:0]  i_funct3,
  input  logic        i_f7b5,
  input  logic [31:0] i_imm,
  output logic [31:0] o_imm_bits,
  output logic        o_fault
);

  // Scatter immediate bits per instruction format.
  always_comb begin
    o_imm_bits = '0;
    unique case (cmd_class_e'(i_class))
      CLS_IALU: begin
        if (i_funct3 == 3'b001 || i_funct3 == 3'b101)
          o_imm_bits[31:20] = {1'b0, i_f7b5, 5'b0, i_imm[4:0]};
        else
          o_imm_bits[31:20] = i_imm[11:0];
      end
      CLS_LOAD, CLS_JALR, CLS_SYSTEM:
        o_imm_bits[31:20] = i_imm[11:0];
      CLS_STORE: begin
        o_imm_bits[31:25] = i_imm[11:5];
        o_imm_bits[11:7]  = i_imm[4:0];
      end
      CLS_BRANCH: begin
        o_imm_bits[31:25] = {i_imm[12], i_imm[10:5]};
        o_imm_bits[11:7]  = {i_imm[4:1], i_imm[11]};
      end
      CLS_JAL:
        o_imm_bits[31:12] = {i_imm[20], i_imm[10:1],
                             i_imm[11], i_imm[19:12]};
      CLS_LUI, CLS_AUIPC:
        o_imm_bits[31:12] = i_imm[31:12];
      default: o_imm_bits = '0;
    endcase
  end

`ifdef INSTR_ENC_CHECK_EN
  // Flag illegal classes and immediates that do not fit the format.
  always_comb begin
    o_fault = 1'b0;
    unique case (cmd_class_e'(i_class))
      CLS_IALU, CLS_LOAD, CLS_JALR, CLS_STORE:
        o_fault = ~fits_signed(i_imm, 12);
      CLS_BRANCH:
        o_fault = ~fits_signed(i_imm, 13) | i_imm[0];
      CLS_JAL:
        o_fault = ~fits_signed(i_imm, 21) | i_imm[0];
      CLS_LUI, CLS_AUIPC:
        o_fault = |i_imm[11:0];
      CLS_R, CLS_SYSTEM:
        o_fault = 1'b0;
      default: o_fault = 1'b1;
    endcase
  end
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I field-level encoder writing consecutive instruction words.
// Optional macro INSTR_ENC_CHECK_EN rejects illegal/out-of-range commands.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_class,
  input  logic [2:0]    cmd_funct3,
  input  logic          cmd_f7b5,
  input  logic [4:0]    cmd_rd,
  input  logic [4:0]    cmd_rs1,
  input  logic [4:0]    cmd_rs2,
  input  logic [31:0]   cmd_imm,
  input  logic          cmd_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count
);

  localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_ready;
  logic          w_ready_nxt;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_waddr;
  logic [31:0]   r_wdata;
  logic          r_err;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic          w_start;
  logic          w_hs;
  logic          w_wr;
  logic          w_fault;
  logic          w_ovf;
  logic [31:0]   w_imm;
  logic [31:0]   w_word;

  assign w_start = (r_state == ST_IDLE) & start;
  assign w_hs    = r_ready & cmd_valid;
  assign w_wr    = w_hs & ~w_fault;
  assign w_ovf   = (r_state == ST_RUN) & (r_count == LP_DEPTH);

  instr_encoder_imm_packer u_imm (
    .i_class    (cmd_class),
    .i_funct3   (cmd_funct3),
    .i_f7b5     (cmd_f7b5),
    .i_imm      (cmd_imm),
    .o_imm_bits (w_imm),
    .o_fault    (w_fault)
  );

  // Assemble the full word; fields unused by a format stay zero.
  always_comb begin
    w_word = NOP;
    unique case (cmd_class_e'(cmd_class))
      CLS_R:
        w_word = {1'b0, cmd_f7b5, 5'b0, cmd_rs2, cmd_rs1,
                  cmd_funct3, cmd_rd, OP_R};
      CLS_IALU:
        w_word = w_imm | {12'b0, cmd_rs1, cmd_funct3,
                          cmd_rd, OP_IALU};
      CLS_LOAD:
        w_word = w_imm | {12'b0, cmd_rs1, cmd_funct3,
                          cmd_rd, OP_LOAD};
      CLS_JALR:
        w_word = w_imm | {12'b0, cmd_rs1, cmd_funct3,
                          cmd_rd, OP_JALR};
      CLS_STORE:
        w_word = w_imm | {7'b0, cmd_rs2, cmd_rs1,
                          cmd_funct3, 5'b0, OP_STORE};
      CLS_BRANCH:
        w_word = w_imm | {7'b0, cmd_rs2, cmd_rs1,
                          cmd_funct3, 5'b0, OP_BRANCH};
      CLS_JAL:
        w_word = w_imm | {20'b0, cmd_rd, OP_JAL};
      CLS_LUI:
        w_word = w_imm | {20'b0, cmd_rd, OP_LUI};
      CLS_AUIPC:
        w_word = w_imm | {20'b0, cmd_rd, OP_AUIPC};
      CLS_SYSTEM:
        w_word = w_imm | {25'b0, OP_SYSTEM};
      default: w_word = NOP;
    endcase
  end

  // Next state, next count and the registered ready it implies.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (w_start)
      w_count_nxt = '0;
    else if (w_wr)
      w_count_nxt = r_count + 1'b1;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_hs & cmd_last)
          w_state_nxt = ST_FLUSH;
        else if (w_ovf)
          w_state_nxt = ST_DONE;
      end
      ST_FLUSH: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == ST_RUN) &
                  (w_count_nxt < LP_DEPTH);
  end

  // FSM state, ready and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Write stage: one-cycle strobe with the word and its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_waddr <= '0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_wdata <= w_word;
        r_waddr <= r_addr;
      end
    end
  end

  // Session address pointer; wraps naturally at 2^AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_addr <= '0;
    else if (w_start)
      r_addr <= base_addr;
    else if (w_wr)
      r_addr <= r_addr + 1'b1;
  end

  // Sticky error, cleared only when a new session opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (w_start)
      r_err <= 1'b0;
    else if ((w_hs & w_fault) | w_ovf)
      r_err <= 1'b1;
  end

  assign cmd_ready  = r_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_waddr;
  assign imem_wdata = r_wdata;
  assign busy       = (r_state == ST_RUN) | (r_state == ST_FLUSH);
  assign done       = (r_state == ST_DONE);
  assign err        = r_err;
  assign count      = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder (AW=10, DEPTH=4).
// Honours INSTR_ENC_CHECK_EN in its reference model.
module tb_instr_encoder;

  localparam int AW    = 10;
  localparam int DEPTH = 4;
`ifdef INSTR_ENC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_class = '0;
  logic [2:0]    cmd_funct3 = '0;
  logic          cmd_f7b5 = 1'b0;
  logic [4:0]    cmd_rd = '0;
  logic [4:0]    cmd_rs1 = '0;
  logic [4:0]    cmd_rs2 = '0;
  logic [31:0]   cmd_imm = '0;
  logic          cmd_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_class(cmd_class),
    .cmd_funct3(cmd_funct3), .cmd_f7b5(cmd_f7b5),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm(cmd_imm), .cmd_last(cmd_last),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .err(err), .count(count)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t           q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  logic [AW-1:0] exp_addr;
  int            nwr;
  bit            exp_err;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v,
                                      input int lo, input int n,
                                      input int dst);
    return ((v >> lo) & ((32'd1 << n) - 32'd1)) << dst;
  endfunction

  // Reference encoder straight from the RV32I format tables.
  function automatic void ref_enc(
    input int cls, input int f3, input int f7,
    input int rd, input int rs1, input int rs2,
    input logic [31:0] imm,
    output bit flt, output logic [31:0] w);
    int s;
    bit bad;
    logic [31:0] frd, ff3, frs1, frs2, ity;
    s    = $signed(imm);
    frd  = 32'(rd) << 7;
    ff3  = 32'(f3) << 12;
    frs1 = 32'(rs1) << 15;
    frs2 = 32'(rs2) << 20;
    ity  = fld(imm, 0, 12, 20);
    bad  = 1'b0;
    case (cls)
      0: w = 32'h33 | frd | ff3 | frs1 | frs2 | (32'(f7) << 30);
      1: begin
        if (f3 == 1 || f3 == 5)
          w = 32'h13 | frd | ff3 | frs1 | (32'(f7) << 30)
              | fld(imm, 0, 5, 20);
        else
          w = 32'h13 | frd | ff3 | frs1 | ity;
        bad = (s < -2048) || (s > 2047);
      end
      2: begin
        w = 32'h03 | frd | ff3 | frs1 | ity;
        bad = (s < -2048) || (s > 2047);
      end
      6: begin
        w = 32'h67 | frd | ff3 | frs1 | ity;
        bad = (s < -2048) || (s > 2047);
      end
      3: begin
        w = 32'h23 | ff3 | frs1 | frs2
            | fld(imm, 5, 7, 25) | fld(imm, 0, 5, 7);
        bad = (s < -2048) || (s > 2047);
      end
      4: begin
        w = 32'h63 | ff3 | frs1 | frs2
            | fld(imm, 12, 1, 31) | fld(imm, 5, 6, 25)
            | fld(imm, 1, 4, 8) | fld(imm, 11, 1, 7);
        bad = (s < -4096) || (s > 4095) || imm[0];
      end
      5: begin
        w = 32'h6F | frd
            | fld(imm, 20, 1, 31) | fld(imm, 1, 10, 21)
            | fld(imm, 11, 1, 20) | fld(imm, 12, 8, 12);
        bad = (s < -(1 << 20)) || (s >= (1 << 20)) || imm[0];
      end
      7: begin
        w = 32'h37 | frd | (imm & 32'hFFFF_F000);
        bad = (imm & 32'hFFF) != 0;
      end
      8: begin
        w = 32'h17 | frd | (imm & 32'hFFFF_F000);
        bad = (imm & 32'hFFF) != 0;
      end
      9: w = 32'h73 | ity;
      default: begin
        w = 32'h13;
        bad = 1'b1;
      end
    endcase
    flt = CHK && bad;
  endfunction

  function automatic logic [31:0] rnd_imm();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return 32'($urandom_range(0, 4095)) - 32'd2048;
      2: return (32'($urandom_range(0, 8191)) - 32'd4096)
                & ~32'd1;
      3: return (32'($urandom_range(0, 2097151)) - 32'd1048576)
                & ~32'd1;
      default: return $urandom & 32'hFFFF_F000;
    endcase
  endfunction

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (imem_we) begin
        if (q.size() == 0) begin
          chk("spurious_we", 32'(imem_we), 32'd0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", 32'(imem_addr), 32'(e.a));
          chk("wr_data", imem_wdata, e.d);
          chk("wr_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_we"}, 32'(imem_we), 0);
    chk({tag, "_addr"}, 32'(imem_addr), 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_count"}, 32'(count), 0);
  endtask

  task automatic open(input logic [AW-1:0] base);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = base;
    nwr = 0;
    exp_err = 1'b0;
    @(negedge clk);
    chk("open_busy", 32'(busy), 1);
    chk("open_ready", 32'(cmd_ready), 1);
    chk("open_count", 32'(count), 0);
    chk("open_err", 32'(err), 0);
    @(posedge clk); #1;
  endtask

  // Offer one command; called just after a rising edge.
  task automatic send(input int cls, input int f3, input int f7,
                      input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm, input bit last,
                      input bit lit_en, input logic [31:0] lit);
    bit flt;
    bit rdy;
    logic [31:0] w;
    cmd_valid  = 1'b1;
    cmd_class  = 4'(cls);
    cmd_funct3 = 3'(f3);
    cmd_f7b5   = 1'(f7);
    cmd_rd     = 5'(rd);
    cmd_rs1    = 5'(rs1);
    cmd_rs2    = 5'(rs2);
    cmd_imm    = imm;
    cmd_last   = last;
    ref_enc(cls, f3, f7, rd, rs1, rs2, imm, flt, w);
    if (lit_en) w = lit;
    rdy = (nwr < DEPTH);
    @(negedge clk);
    chk("cmd_ready", 32'(cmd_ready), 32'(rdy));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (rdy) begin
      if (flt) begin
        exp_err = 1'b1;
      end else begin
        q.push_back('{cyc, exp_addr, w});
        exp_addr = exp_addr + 1'b1;
        nwr++;
      end
    end
  endtask

  task automatic rand_cmd(input bit last);
    int cls;
    if ($urandom_range(0, 19) < 18)
      cls = $urandom_range(0, 9);
    else
      cls = $urandom_range(10, 15);
    send(cls, $urandom_range(0, 7), $urandom_range(0, 1),
         $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), rnd_imm(), last, 1'b0, '0);
  endtask

  task automatic close();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_pulse", 32'(seen), 1);
    chk("end_count", 32'(count), 32'(nwr));
    chk("end_err", 32'(err), 32'(exp_err));
    chk("q_drained", q.size(), 0);
    @(negedge clk);
    chk("done_1cyc", 32'(done), 0);
    chk("busy_end", 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int len;
    fork
      monitor();
      forever begin @(posedge clk); cyc++; end
      begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
      end
    join_none

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    outs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // add x3,x1,x2 as a single-command session
    open(10'h010);
    send(0, 0, 0, 3, 1, 2, 32'd0, 1'b1, 1'b1, 32'h002081B3);
    close();

    // addi / sw / beq back-to-back; start mid-run is ignored
    open(10'h020);
    send(1, 0, 0, 5, 0, 9, 32'hFFFF_FFFF, 1'b0,
         1'b1, 32'hFFF00293);
    start = 1'b1;
    base_addr = 10'h155;
    send(3, 2, 0, 31, 2, 5, 32'd8, 1'b0, 1'b1, 32'h00512423);
    start = 1'b0;
    send(4, 0, 1, 7, 1, 2, 32'hFFFF_FFFC, 1'b1,
         1'b1, 32'hFE208EE3);
    close();

    // lui / jal / jalr
    open(10'h040);
    send(7, 3, 1, 7, 9, 4, 32'h12345000, 1'b0,
         1'b1, 32'h123453B7);
    send(5, 6, 0, 1, 3, 3, 32'd2048, 1'b0, 1'b1, 32'h001000EF);
    send(6, 0, 0, 0, 1, 17, 32'd0, 1'b1, 1'b1, 32'h00008067);
    close();

    // five commands without last against DEPTH=4
    open(10'h100);
    for (int k = 0; k < 5; k++)
      send(0, k, 0, k + 1, k + 2, k + 3, 32'd0, 1'b0, 1'b0, '0);
    exp_err = 1'b1;
    close();

    // out-of-range addi and illegal class
    open(10'h080);
    send(1, 0, 0, 4, 2, 0, 32'd4096, 1'b0, 1'b0, '0);
    send(12, 5, 1, 9, 9, 9, $urandom, 1'b1, 1'b0, '0);
    close();

    // address wrap at the top of the map
    open(10'h3FF);
    send(0, 7, 0, 1, 2, 3, 32'd0, 1'b0, 1'b0, '0);
    send(0, 4, 1, 4, 5, 6, 32'd0, 1'b1, 1'b0, '0);
    close();

    // randomized sessions with idle gaps
    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(1, 4);
      open(AW'($urandom));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        rand_cmd(k == len - 1);
      end
      close();
    end

    // reset one cycle after a handshake abandons the write
    open(10'h020);
    cmd_valid = 1'b1;
    cmd_class = 4'd0;
    cmd_last = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    outs_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_we", 32'(imem_we), 0);
    chk("post_rst_q", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
